// File: rtl/calc_pkg.sv
// Shared constants for the calculator front end: key codes, operator and
// save_enable encodings, sequencer states and the key-matrix map.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQU = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  localparam logic [1:0] OPR_ADD = 2'b00;
  localparam logic [1:0] OPR_SUB = 2'b01;
  localparam logic [1:0] OPR_MUL = 2'b10;
  localparam logic [1:0] OPR_DIV = 2'b11;

  localparam logic [1:0] SAVE_NONE = 2'b00;
  localparam logic [1:0] SAVE_OP1  = 2'b01;
  localparam logic [1:0] SAVE_OPR  = 2'b10;
  localparam logic [1:0] SAVE_OP2  = 2'b11;

  typedef enum logic [1:0] {
    S_OP1 = 2'd0,
    S_OP2 = 2'd1,
    S_RES = 2'd2
  } seq_state_e;

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = KEY_ADD;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = KEY_SUB;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = KEY_MUL;
      4'b11_00: code = KEY_CLR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_EQU;
      default:  code = KEY_DIV;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// Column scanner, per-frame key capture and debouncer for the 4x4 matrix.
// Emits a single key_valid pulse per accepted press.
module keypad_scan
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE);

  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      col_q, col_d;
  logic            hit_q, hit_d;
  logic [3:0]      hit_code_q, hit_code_d;
  logic            prev_vld_q, prev_vld_d;
  logic [3:0]      prev_code_q, prev_code_d;
  logic [CntW-1:0] stable_q, stable_d;
  logic            armed_q, armed_d;
  logic            key_valid_q, key_valid_d;
  logic [3:0]      key_code_q, key_code_d;

  logic            slot_end, frame_end, row_hit, same;
  logic [1:0]      row_sel;
  logic            fvld;
  logic [3:0]      fcode;
  logic [CntW-1:0] stable_nx;

  // Lowest-numbered low row wins within a column.
  always_comb begin
    row_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row[i]) row_sel = 2'(i);
    end
  end

  always_comb begin
    slot_end  = (div_q == DivLast);
    frame_end = slot_end && (idx_q == 2'd3);
    row_hit   = (row != 4'hF);
    fvld      = hit_q || (slot_end && row_hit);
    fcode     = hit_q ? hit_code_q : key_lookup(row_sel, idx_q);
    same      = (fvld == prev_vld_q) && (!fvld || (fcode == prev_code_q));
    if (!same)                  stable_nx = CntW'(1);
    else if (stable_q < CntMax) stable_nx = stable_q + 1'b1;
    else                        stable_nx = CntMax;
  end

  always_comb begin
    div_d       = slot_end ? '0 : div_q + 1'b1;
    idx_d       = idx_q;
    col_d       = col_q;
    hit_d       = hit_q;
    hit_code_d  = hit_code_q;
    prev_vld_d  = prev_vld_q;
    prev_code_d = prev_code_q;
    stable_d    = stable_q;
    armed_d     = armed_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;

    if (slot_end) begin
      idx_d = idx_q + 2'd1;
      col_d = ~(4'b0001 << idx_d);
      if (!hit_q && row_hit) begin
        hit_d      = 1'b1;
        hit_code_d = fcode;
      end
    end

    if (frame_end) begin
      hit_d       = 1'b0;
      prev_vld_d  = fvld;
      prev_code_d = fcode;
      stable_d    = stable_nx;
      if (fvld && armed_q && (stable_nx == CntMax)) begin
        key_valid_d = 1'b1;
        key_code_d  = fcode;
        armed_d     = 1'b0;
      end else if (!fvld && (stable_nx == CntMax)) begin
        armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      idx_q       <= 2'd0;
      col_q       <= 4'b1110;
      hit_q       <= 1'b0;
      hit_code_q  <= 4'd0;
      prev_vld_q  <= 1'b0;
      prev_code_q <= 4'd0;
      stable_q    <= '0;
      armed_q     <= 1'b1;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      col_q       <= col_d;
      hit_q       <= hit_d;
      hit_code_q  <= hit_code_d;
      prev_vld_q  <= prev_vld_d;
      prev_code_q <= prev_code_d;
      stable_q    <= stable_d;
      armed_q     <= armed_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  assign col       = col_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: rtl/keypad_ctrl.sv
// Calculator front end: keypad scanner plus the entry sequencer that drives
// the memory stage with registered strobes and held num/operator values.
module keypad_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] num,
  output logic [1:0] operator,
  output logic [1:0] save_enable,
  output logic       clear_enable,
  output logic       equ_enable,
  output logic       op_enable
);

  logic       key_valid;
  logic [3:0] key_code;

  keypad_scan #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  seq_state_e state_q, state_d;
  logic [2:0] dcnt_q, dcnt_d;
  logic [3:0] num_q, num_d;
  logic [1:0] opr_q, opr_d;
  logic [1:0] save_q, save_d;
  logic       clr_q, clr_d;
  logic       equ_q, equ_d;
  logic       ope_q, ope_d;
  logic       pend_q, pend_d;
  logic [3:0] pend_dig_q, pend_dig_d;

  logic       is_dig, is_op, is_equ, is_clr;
  logic [3:0] opr_off;

  always_comb begin
    is_dig  = (key_code <= 4'd9);
    is_op   = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
    is_equ  = (key_code == KEY_EQU);
    is_clr  = (key_code == KEY_CLR);
    opr_off = key_code - KEY_ADD;
  end

  always_comb begin
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    num_d      = num_q;
    opr_d      = opr_q;
    save_d     = SAVE_NONE;
    clr_d      = 1'b0;
    equ_d      = 1'b0;
    ope_d      = 1'b0;
    pend_d     = 1'b0;
    pend_dig_d = pend_dig_q;

    if (key_valid && is_clr) begin
      clr_d   = 1'b1;
      dcnt_d  = 3'd0;
      state_d = S_OP1;
    end else if (pend_q) begin
      // Second half of a digit typed after '=': clear went out last cycle.
      num_d   = pend_dig_q;
      save_d  = SAVE_OP1;
      dcnt_d  = 3'd1;
      state_d = S_OP1;
    end else if (key_valid) begin
      case (state_q)
        S_OP1: begin
          if (is_dig && (dcnt_q < 3'd4)) begin
            num_d  = key_code;
            save_d = SAVE_OP1;
            dcnt_d = dcnt_q + 3'd1;
          end else if (is_op && (dcnt_q != 3'd0)) begin
            opr_d   = opr_off[1:0];
            save_d  = SAVE_OPR;
            dcnt_d  = 3'd0;
            state_d = S_OP2;
          end
        end
        S_OP2: begin
          if (is_dig && (dcnt_q < 3'd4)) begin
            num_d  = key_code;
            save_d = SAVE_OP2;
            dcnt_d = dcnt_q + 3'd1;
          end else if (is_op && (dcnt_q == 3'd0)) begin
            opr_d  = opr_off[1:0];
            save_d = SAVE_OPR;
          end else if (is_equ && (dcnt_q != 3'd0)) begin
            equ_d   = 1'b1;
            state_d = S_RES;
          end
        end
        S_RES: begin
          if (is_dig) begin
            clr_d      = 1'b1;
            pend_d     = 1'b1;
            pend_dig_d = key_code;
          end else if (is_op) begin
            ope_d   = 1'b1;
            opr_d   = opr_off[1:0];
            save_d  = SAVE_OPR;
            dcnt_d  = 3'd0;
            state_d = S_OP2;
          end
        end
        default: state_d = S_OP1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_OP1;
      dcnt_q     <= 3'd0;
      num_q      <= 4'd0;
      opr_q      <= OPR_ADD;
      save_q     <= SAVE_NONE;
      clr_q      <= 1'b0;
      equ_q      <= 1'b0;
      ope_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_dig_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      num_q      <= num_d;
      opr_q      <= opr_d;
      save_q     <= save_d;
      clr_q      <= clr_d;
      equ_q      <= equ_d;
      ope_q      <= ope_d;
      pend_q     <= pend_d;
      pend_dig_q <= pend_dig_d;
    end
  end

  assign num          = num_q;
  assign operator     = opr_q;
  assign save_enable  = save_q;
  assign clear_enable = clr_q;
  assign equ_enable   = equ_q;
  assign op_enable    = ope_q;

endmodule

// File: tb/tb_keypad_ctrl.sv
// Directed bench for keypad_ctrl with SCAN_DIV=2, DEBOUNCE=2 (8-cycle frames);
// strobe cycles are logged and compared against hand-computed events.
module tb_keypad_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] num;
  logic [1:0] operator;
  logic [1:0] save_enable;
  logic       clear_enable;
  logic       equ_enable;
  logic       op_enable;

  logic [15:0] pressed = 16'h0;
  int unsigned cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  save;
    logic        clr;
    logic        equ;
    logic        ope;
    logic [3:0]  num;
    logic [1:0]  opr;
  } evt_t;

  evt_t evq[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  keypad_ctrl #(
    .SCAN_DIV(2),
    .DEBOUNCE(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row         (row),
    .col         (col),
    .num         (num),
    .operator    (operator),
    .save_enable (save_enable),
    .clear_enable(clear_enable),
    .equ_enable  (equ_enable),
    .op_enable   (op_enable)
  );

  always @(negedge clk) begin
    if (!rst && ((save_enable != 2'b00) || clear_enable || equ_enable || op_enable)) begin
      evq.push_back('{cyc, save_enable, clear_enable, equ_enable, op_enable, num, operator});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_evt(input string tag, input logic [1:0] save, input logic clr,
                            input logic equ, input logic ope, input logic [3:0] n,
                            input logic [1:0] opr, output int unsigned at);
    evt_t e;
    at = 0;
    if (evq.size() == 0) begin
      check_eq({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      e  = evq.pop_front();
      at = e.cyc;
      check_eq({tag, "_save"}, 32'(e.save), 32'(save));
      check_eq({tag, "_clr"},  32'(e.clr),  32'(clr));
      check_eq({tag, "_equ"},  32'(e.equ),  32'(equ));
      check_eq({tag, "_ope"},  32'(e.ope),  32'(ope));
      check_eq({tag, "_num"},  32'(e.num),  32'(n));
      check_eq({tag, "_opr"},  32'(e.opr),  32'(opr));
    end
  endtask

  task automatic expect_quiet(input string tag);
    check_eq({tag, "_none"}, 32'(evq.size()), 32'd0);
    evq.delete();
  endtask

  task automatic tap(input int r, input int c);
    pressed[r*4+c] = 1'b1;
    repeat (32) @(negedge clk);
    pressed[r*4+c] = 1'b0;
    repeat (32) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    pressed = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    evq.delete();
  endtask

  initial begin
    int unsigned t0, t1;
    logic [3:0]  exp_col;

    // Reset state and column rotation
    repeat (3) @(negedge clk);
    check_eq("rst_col", 32'(col), 32'h0000000E);
    check_eq("rst_save", 32'(save_enable), 32'd0);
    check_eq("rst_strb", 32'({clear_enable, equ_enable, op_enable}), 32'd0);
    check_eq("rst_num", 32'(num), 32'd0);
    check_eq("rst_opr", 32'(operator), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((k / 2) % 4));
      check_eq($sformatf("scan_col%0d", k), 32'(col), 32'(exp_col));
    end

    // Bounce then long hold of '5': one event only
    pressed[5] = 1'b1;
    repeat (3) @(negedge clk);
    pressed[5] = 1'b0;
    repeat (5) @(negedge clk);
    pressed[5] = 1'b1;
    repeat (48) @(negedge clk);
    expect_evt("hold5", 2'b01, 1'b0, 1'b0, 1'b0, 4'd5, 2'b00, t0);
    expect_quiet("hold5_single");
    // One empty frame is not enough to re-arm
    pressed[5] = 1'b0;
    repeat (8) @(negedge clk);
    pressed[5] = 1'b1;
    repeat (32) @(negedge clk);
    pressed[5] = 1'b0;
    repeat (32) @(negedge clk);
    expect_quiet("short_release");
    tap(1, 1);
    expect_evt("rearm5", 2'b01, 1'b0, 1'b0, 1'b0, 4'd5, 2'b00, t0);

    // 1 2 + 7 =
    do_reset();
    tap(0, 0);
    expect_evt("d1", 2'b01, 1'b0, 1'b0, 1'b0, 4'd1, 2'b00, t0);
    tap(0, 1);
    expect_evt("d2", 2'b01, 1'b0, 1'b0, 1'b0, 4'd2, 2'b00, t0);
    tap(0, 3);
    expect_evt("add", 2'b10, 1'b0, 1'b0, 1'b0, 4'd2, 2'b00, t0);
    tap(2, 0);
    expect_evt("d7", 2'b11, 1'b0, 1'b0, 1'b0, 4'd7, 2'b00, t0);
    tap(3, 2);
    expect_evt("equ1", 2'b00, 1'b0, 1'b1, 1'b0, 4'd7, 2'b00, t0);
    expect_quiet("seq1");

    // Chaining from the result
    tap(2, 3);
    expect_evt("chain_mul", 2'b10, 1'b0, 1'b0, 1'b1, 4'd7, 2'b10, t0);
    tap(1, 0);
    expect_evt("d4", 2'b11, 1'b0, 1'b0, 1'b0, 4'd4, 2'b10, t0);
    tap(3, 2);
    expect_evt("equ2", 2'b00, 1'b0, 1'b1, 1'b0, 4'd4, 2'b10, t0);
    tap(0, 2);
    expect_evt("res_clr", 2'b00, 1'b1, 1'b0, 1'b0, 4'd4, 2'b10, t0);
    expect_evt("res_d3", 2'b01, 1'b0, 1'b0, 1'b0, 4'd3, 2'b10, t1);
    check_eq("defer_lat", t1 - t0, 32'd1);
    expect_quiet("chain");

    // Entry limits and clear
    do_reset();
    tap(0, 3);
    expect_quiet("op_first");
    tap(0, 0);
    tap(0, 1);
    tap(0, 2);
    tap(1, 0);
    tap(1, 1);
    expect_evt("lim1", 2'b01, 1'b0, 1'b0, 1'b0, 4'd1, 2'b00, t0);
    expect_evt("lim2", 2'b01, 1'b0, 1'b0, 1'b0, 4'd2, 2'b00, t0);
    expect_evt("lim3", 2'b01, 1'b0, 1'b0, 1'b0, 4'd3, 2'b00, t0);
    expect_evt("lim4", 2'b01, 1'b0, 1'b0, 1'b0, 4'd4, 2'b00, t0);
    expect_quiet("lim5");
    tap(0, 3);
    expect_evt("lim_add", 2'b10, 1'b0, 1'b0, 1'b0, 4'd4, 2'b00, t0);
    tap(3, 2);
    expect_quiet("equ_dcnt0");
    tap(1, 3);
    expect_evt("op_replace", 2'b10, 1'b0, 1'b0, 1'b0, 4'd4, 2'b01, t0);
    tap(1, 2);
    expect_evt("d6", 2'b11, 1'b0, 1'b0, 1'b0, 4'd6, 2'b01, t0);
    tap(3, 0);
    expect_evt("clear", 2'b00, 1'b1, 1'b0, 1'b0, 4'd6, 2'b01, t0);
    tap(0, 3);
    expect_quiet("op_after_clr");
    tap(2, 1);
    expect_evt("d8", 2'b01, 1'b0, 1'b0, 1'b0, 4'd8, 2'b01, t0);

    // Two keys at once: lowest column wins
    pressed[0]  = 1'b1;
    pressed[10] = 1'b1;
    repeat (32) @(negedge clk);
    pressed = 16'h0;
    repeat (32) @(negedge clk);
    expect_evt("multi", 2'b01, 1'b0, 1'b0, 1'b0, 4'd1, 2'b01, t0);
    expect_quiet("multi_single");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
